// File: rtl/stack_pkg.sv
// Shared definitions for the parametrised LIFO stack:
// op codes, op width and the width helper.
package stack_pkg;

    localparam int OPW = 3;

    typedef enum logic [OPW-1:0] {
        OP_NOP     = 3'd0,
        OP_PUSH    = 3'd1,
        OP_POP     = 3'd2,
        OP_SWAP    = 3'd3,
        OP_DUP     = 3'd4,
        OP_REPLACE = 3'd5,
        OP_CLEAR   = 3'd6,
        OP_RSVD    = 3'd7
    } op_e;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stack_regfile.sv
// Entry storage for param_stack: one write port, a two-entry
// swap strobe, a clear-all strobe and three combinational reads.
module stack_regfile
    import stack_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int IW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             swap,
    input  logic [IW-1:0]    saddr,
    input  logic             clr,
    input  logic [IW-1:0]    ta,
    input  logic [IW-1:0]    na,
    input  logic [IW-1:0]    pa,
    output logic [WIDTH-1:0] td,
    output logic [WIDTH-1:0] nd,
    output logic [WIDTH-1:0] pd
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [IW-1:0]    sb;

    // swap exchanges saddr with the entry directly above it
    assign sb = saddr + IW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '{default: '0};
        end else if (clr) begin
            mem <= '{default: '0};
        end else if (swap) begin
            mem[saddr] <= mem[sb];
            mem[sb]    <= mem[saddr];
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign td = mem[ta];
    assign nd = mem[na];
    assign pd = mem[pa];

endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO stack: count, op decode with legality
// checks, sticky overflow/underflow flags and an error pulse.
module param_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CW    = clog2(DEPTH + 1),
    parameter int IW    = clog2(DEPTH)
) (
    input  logic             ctl,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top_data,
    output logic [WIDTH-1:0] next_data,
    input  logic [IW-1:0]    peek_idx,
    output logic [WIDTH-1:0] peek_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow,
    output logic             err,
    input  logic             err_clr
);

    logic             lt2;
    logic             pk_ok;
    logic [IW-1:0]    ta;
    logic [IW-1:0]    na;
    logic [IW-1:0]    pa;
    logic [IW-1:0]    wa;
    logic [WIDTH-1:0] td;
    logic [WIDTH-1:0] nd;
    logic [WIDTH-1:0] pd;

    logic             we;
    logic [IW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic             swap;
    logic             clr;
    logic [CW-1:0]    cnt_nxt;
    logic             ovf_ev;
    logic             unf_ev;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign lt2   = (count < CW'(2));
    assign pk_ok = (CW'(peek_idx) < count);

    assign ta = IW'(count - CW'(1));
    assign na = IW'(count - CW'(2));
    assign pa = IW'(count - CW'(1) - CW'(peek_idx));
    assign wa = IW'(count);

    // index arithmetic wraps when out of range, so gate the reads
    assign top_data  = empty ? '0 : td;
    assign next_data = lt2   ? '0 : nd;
    assign peek_data = pk_ok ? pd : '0;

    always_comb begin
        we      = 1'b0;
        waddr   = wa;
        wdata   = din;
        swap    = 1'b0;
        clr     = 1'b0;
        cnt_nxt = count;
        ovf_ev  = 1'b0;
        unf_ev  = 1'b0;
        if (op_valid) begin
            unique case (op_e'(op))
                OP_PUSH: begin
                    if (full) begin
                        ovf_ev = 1'b1;
                    end else begin
                        we      = 1'b1;
                        cnt_nxt = count + CW'(1);
                    end
                end
                OP_POP: begin
                    if (empty) begin
                        unf_ev = 1'b1;
                    end else begin
                        we      = 1'b1;
                        waddr   = ta;
                        wdata   = '0;
                        cnt_nxt = count - CW'(1);
                    end
                end
                OP_SWAP: begin
                    if (lt2) unf_ev = 1'b1;
                    else     swap   = 1'b1;
                end
                OP_DUP: begin
                    if (empty) begin
                        unf_ev = 1'b1;
                    end else if (full) begin
                        ovf_ev = 1'b1;
                    end else begin
                        we      = 1'b1;
                        wdata   = td;
                        cnt_nxt = count + CW'(1);
                    end
                end
                OP_REPLACE: begin
                    if (empty) begin
                        unf_ev = 1'b1;
                    end else begin
                        we    = 1'b1;
                        waddr = ta;
                    end
                end
                OP_CLEAR: begin
                    clr     = 1'b1;
                    cnt_nxt = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge ctl or posedge rst) begin
        if (rst) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            err       <= 1'b0;
        end else begin
            count <= cnt_nxt;
            err   <= ovf_ev | unf_ev;
            if (clr) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else begin
                overflow  <= ovf_ev | (overflow & ~err_clr);
                underflow <= unf_ev | (underflow & ~err_clr);
            end
        end
    end

    stack_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_rf (
        .clk   (ctl),
        .rst   (rst),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .swap  (swap),
        .saddr (na),
        .clr   (clr),
        .ta    (ta),
        .na    (na),
        .pa    (pa),
        .td    (td),
        .nd    (nd),
        .pd    (pd)
    );

endmodule

// File: doc/param_stack.md
Name: param_stack

Overview:
- Parametrised LIFO stack: the next generation of the team's fixed 4x4-bit stack.
- Generalised in data width and depth; adds DUP, REPLACE and CLEAR ops, sticky overflow/underflow flags, an error pulse, and an indexed peek port.
- Sits between the switch/keypad input decoder and the 7-seg/LED display logic.
- Also usable as an operand stack for the RPN calculator datapath.

Parameters:
- WIDTH, 4: bits per stack entry.
- DEPTH, 4: number of entries; must be >= 2.
- CW, $clog2(DEPTH+1): width of the count output (derived; not overridden).
- IW, $clog2(DEPTH): width of the peek index (derived).

Ports:
- ctl  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- op_valid  input  1  qualifies op; when low the cycle is a NOP.
- op  input  3  0=NOP 1=PUSH 2=POP 3=SWAP 4=DUP 5=REPLACE 6=CLEAR 7=reserved (NOP).
- din  input  WIDTH  data for PUSH/REPLACE.
- top_data  output  WIDTH  entry at the top of the stack; 0 when empty.
- next_data  output  WIDTH  entry second from the top; 0 when count<2.
- peek_idx  input  IW  index counted from the top (0=top).
- peek_data  output  WIDTH  entry at peek_idx; 0 if peek_idx>=count.
- count  output  CW  number of valid entries.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.
- overflow  output  1  sticky; set by a rejected op due to full.
- underflow  output  1  sticky; set by a rejected op due to too few entries.
- err  output  1  one-cycle pulse in the cycle after any rejected op.
- err_clr  input  1  clears overflow/underflow at the next edge.

Behaviour:
- Reset (async, rst=1): all entries=0, count=0, overflow=0, underflow=0, err=0. Hence top_data=next_data=peek_data=0, empty=1, full=0. Ops are ignored while rst=1.
- Storage: mem[0..DEPTH-1], mem[0] is the bottom, top is mem[count-1]. Outputs top_data, next_data, peek_data, full and empty are combinational decodes of registered state. Latency of every op is one ctl edge.
- PUSH:
  - count<DEPTH: mem[count]<=din, count+1.
  - full: no state change, overflow<=1, err pulse.
- POP:
  - count>0: mem[count-1]<=0 (a vacated slot always reads 0), count-1.
  - empty: underflow<=1, err pulse.
- SWAP:
  - count>=2: exchange mem[count-1] and mem[count-2]; count unchanged.
  - count<2: no change, underflow<=1, err pulse.
- DUP:
  - 0<count<DEPTH: mem[count]<=mem[count-1], count+1.
  - empty: underflow<=1, err pulse.
  - full: overflow<=1, err pulse.
- REPLACE:
  - count>0: mem[count-1]<=din; count unchanged.
  - empty: underflow<=1, err pulse.
- CLEAR: all entries<=0, count<=0, overflow<=0, underflow<=0. Never an error.
- NOP / reserved / op_valid=0: state holds; err<=0.
- Error flags:
  - overflow and underflow stay set until err_clr, CLEAR or rst.
  - err_clr in the same cycle as a new rejected op: the new error's flag ends at 1; the other flag clears.
  - A successful op never clears the sticky flags.
- err is registered: high for exactly one cycle after a rejected op; back-to-back rejected ops hold it high.
- Boundaries:
  - Rejected ops leave mem and count bit-exact unchanged.
  - count never exceeds DEPTH and never wraps below 0.
- Reset asserted mid-sequence takes effect immediately, regardless of ctl. The first op sampled after rst falls executes normally.

Decomposition:
- Package stack_pkg:
  - op codes as localparams/enum OP_NOP..OP_CLEAR.
  - Op width constant OPW=3.
  - Function clog2 helper for CW/IW.
- One sub-module, stack_regfile(WIDTH, DEPTH):
  - Entry array with async clear.
  - Single write port (addr, data, we).
  - Swap strobe (writes two entries).
  - Clear-all strobe.
  - Three combinational read ports (top, next, peek).
- param_stack holds count, the op decode/legality check, and the flag logic.

Test Plan:
- Reset then PUSH 3,7,9,5 (WIDTH=4, DEPTH=4) -> count=4, full=1, top=5, next=9, peek_idx=3 reads 3. PUSH 2 -> overflow=1, err=1 for one cycle, contents unchanged.
- From the full stack {3,7,9,5}:
  - SWAP -> top=9, next=5.
  - POP x4 -> count=0, empty=1, top=0.
  - A further POP -> underflow=1, err pulse; overflow still 1.
- err_clr with NOP -> both flags 0. Then err_clr with POP on empty in the same cycle -> underflow=1, overflow=0.
- Single-entry cases:
  - PUSH 6, SWAP -> underflow=1, count=1, top=6.
  - DUP -> count=2, top=next=6.
  - REPLACE 0xA -> top=0xA, next=6.
- With the stack at count=3, assert rst asynchronously between edges -> count=0 and all outputs 0 immediately. Release rst, then PUSH 1 -> count=1, top=1.
- Regression at WIDTH=8, DEPTH=16:
  - 16 PUSHes of i*17 -> full=1; peek_idx=15 reads 0.
  - CLEAR -> empty=1, flags 0, peek_idx=0 reads 0.
